// File: rtl/shift_pipe_if.sv
// shift_pipe_if -- handshake bundle for the two-stage shifter pipeline.
//
// Input side : in_valid/in_ready handshake carrying in_data, in_amt,
//              in_op and in_tag.
// Output side: out_valid/out_ready handshake carrying out_data, out_tag
//              and out_zero.
// master: producer/consumer environment around the shifter.
// slave : the shifter itself.
interface shift_pipe_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   localparam int AMT_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;

   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_zero
   );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe -- two-stage elastic barrel shifter (SLL/SRL/SRA/ROL/ROR).
//
// S1 applies the low shift levels (1, 2, .. 2^(K-1)), S2 applies the rest
// and registers the result together with its zero flag. Each stage holds
// a valid bit; a full stage only moves forward when the stage after it
// moves, so beats are never dropped or reordered.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, empties both stages
//   bus    - shift_pipe_if.slave: input beat handshake and result handshake
//
// Configuration:
//   SHIFT_PIPE_ROTATE_EN - when defined, ROL/ROR rotate; otherwise the
//                          rotate logic is left out and ROL acts as SLL,
//                          ROR as SRL.
module shift_pipe #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_pipe_if.slave bus
);
   localparam int AMT_W = $clog2(WIDTH);
   // number of levels handled by S1: ceil(log2(WIDTH)/2)
   localparam int K     = (AMT_W + 1) / 2;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   function automatic logic [WIDTH-1:0] shift_by(
      input logic [WIDTH-1:0] d,
      input int               sh,
      input logic [2:0]       op
   );
      logic [WIDTH-1:0] r;
      r = d;
      case (op)
         OP_SLL: r = d << sh;
         OP_SRL: r = d >> sh;
         // the MSB survives every arithmetic level, so splitting SRA
         // across the stages still replicates the original sign bit
         OP_SRA: r = $unsigned($signed(d) >>> sh);
`ifdef SHIFT_PIPE_ROTATE_EN
         OP_ROL: r = (d << sh) | (d >> (WIDTH - sh));
         OP_ROR: r = (d >> sh) | (d << (WIDTH - sh));
`else
         OP_ROL: r = d << sh;
         OP_ROR: r = d >> sh;
`endif
         default: r = d;
      endcase
      return r;
   endfunction

   // apply levels lo..hi-1 of the log shifter
   function automatic logic [WIDTH-1:0] shift_levels(
      input logic [WIDTH-1:0] d,
      input logic [AMT_W-1:0] amt,
      input logic [2:0]       op,
      input int               lo,
      input int               hi
   );
      logic [WIDTH-1:0] r;
      r = d;
      for (int i = 0; i < AMT_W; i++) begin
         if (i >= lo && i < hi && amt[i]) begin
            r = shift_by(r, 1 << i, op);
         end
      end
      return r;
   endfunction

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [AMT_W-1:0] s1_amt;
   logic [2:0]       s1_op;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;
   logic [TAG_W-1:0] s2_tag;
   logic             s2_zero;

   logic             s2_adv;
   logic             s1_adv;
   logic [WIDTH-1:0] s1_next;
   logic [WIDTH-1:0] s2_next;

   assign s2_adv  = bus.out_ready | ~s2_valid;
   assign s1_adv  = s2_adv | ~s1_valid;

   assign s1_next = shift_levels(bus.in_data, bus.in_amt, bus.in_op, 0, K);
   assign s2_next = shift_levels(s1_data, s1_amt, s1_op, K, AMT_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_amt   <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_tag   <= '0;
         s2_zero  <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            // payload only loads with a real beat so idle cycles leave
            // the output registers quiet
            if (s1_valid) begin
               s2_data <= s2_next;
               s2_tag  <= s1_tag;
               s2_zero <= (s2_next == '0);
            end
         end
         if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_data <= s1_next;
               s1_amt  <= bus.in_amt;
               s1_op   <= bus.in_op;
               s1_tag  <= bus.in_tag;
            end
         end
      end
   end

   // combinational from out_ready through s2_adv
   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_tag   = s2_tag;
   assign bus.out_zero  = s2_zero;
endmodule
